// File: rtl/isqrt_rr_arbiter.sv
// Round-robin front end that lets N_REQ requesters share one fixed-latency isqrt unit.
// An in-order tag FIFO routes each returning result back to the requester that issued it.
module isqrt_rr_arbiter #(
  parameter int N_REQ   = 2,
  parameter int MAX_OUT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_vld,
  input  logic [N_REQ*32-1:0]  req_x,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     rsp_vld,
  output logic [15:0]          rsp_y,
  output logic                 isqrt_x_vld,
  output logic [31:0]          isqrt_x,
  input  logic                 isqrt_y_vld,
  input  logic [15:0]          isqrt_y,
  output logic                 busy,
  output logic                 err_unexpected
);
  // Handshake: a request transfers on a rising edge where req_vld[i] & req_ready[i];
  // req_ready depends only on registered state and req_vld, never on isqrt_y_vld.

  localparam int PW = $clog2(MAX_OUT);
  localparam int RW = $clog2(N_REQ);

  logic [PW:0]       cnt_q, cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [RW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]  rsp_vld_q, rsp_vld_d;
  logic [15:0]       rsp_y_q, rsp_y_d;
  logic              err_q, err_d;
  logic [RW-1:0]     tag_mem_q [MAX_OUT];

  logic              can_issue;
  logic              any_vld;
  logic [RW-1:0]     grant;
  logic [RW:0]       idx;
  logic [31:0]       x_sel;
  logic              issue;
  logic              pop;

  assign can_issue = (cnt_q < (PW+1)'(MAX_OUT));

  // Walk downwards so the candidate closest to rr_ptr is the last one to win.
  always_comb begin
    grant   = '0;
    any_vld = 1'b0;
    idx     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr_q} + (RW+1)'(k);
      if (idx >= (RW+1)'(N_REQ)) idx = idx - (RW+1)'(N_REQ);
      if (req_vld[idx[RW-1:0]]) begin
        grant   = idx[RW-1:0];
        any_vld = 1'b1;
      end
    end
  end

  always_comb begin
    x_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == RW'(i)) x_sel = req_x[32*i +: 32];
    end
  end

  assign issue       = any_vld & can_issue;
  assign pop         = isqrt_y_vld & (cnt_q != '0);
  assign isqrt_x_vld = issue;
  assign isqrt_x     = issue ? x_sel : '0;
  assign req_ready   = issue ? ((N_REQ)'(1) << grant) : '0;

  always_comb begin
    cnt_d     = cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rr_ptr_d  = rr_ptr_q;
    rsp_vld_d = '0;
    rsp_y_d   = rsp_y_q;
    err_d     = err_q;
    if (issue) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      rr_ptr_d = (grant == RW'(N_REQ - 1)) ? '0 : grant + RW'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      rsp_vld_d = (N_REQ)'(1) << tag_mem_q[rd_ptr_q];
      rsp_y_d   = isqrt_y;
    end
    if (isqrt_y_vld && (cnt_q == '0)) err_d = 1'b1;
    if (issue && !pop) cnt_d = cnt_q + (PW+1)'(1);
    else if (!issue && pop) cnt_d = cnt_q - (PW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rr_ptr_q  <= '0;
      rsp_vld_q <= '0;
      rsp_y_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rr_ptr_q  <= rr_ptr_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_y_q   <= rsp_y_d;
      err_q     <= err_d;
    end
  end

  // Tag storage needs no reset: entries are only read behind a valid write.
  always_ff @(posedge clk) begin
    if (issue) tag_mem_q[wr_ptr_q] <= grant;
  end

  assign rsp_vld        = rsp_vld_q;
  assign rsp_y          = rsp_y_q;
  assign busy           = (cnt_q != '0);
  assign err_unexpected = err_q;

endmodule

// File: tb/tb_isqrt_rr_arbiter.sv
// Bench for isqrt_rr_arbiter: behavioural isqrt stub, random/directed requesters,
// reference model of arbitration/occupancy and a response scoreboard.
module tb_isqrt_rr_arbiter;
  localparam int N       = 2;
  localparam int MAX_OUT = 4;
  localparam int W       = 24;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    req_vld;
  logic [N*32-1:0] req_x;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_vld;
  logic [15:0]     rsp_y;
  logic            isqrt_x_vld;
  logic [31:0]     isqrt_x;
  logic            isqrt_y_vld;
  logic [15:0]     isqrt_y;
  logic            busy;
  logic            err_unexpected;

  isqrt_rr_arbiter #(.N_REQ(N), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_x(req_x), .req_ready(req_ready),
    .rsp_vld(rsp_vld), .rsp_y(rsp_y),
    .isqrt_x_vld(isqrt_x_vld), .isqrt_x(isqrt_x),
    .isqrt_y_vld(isqrt_y_vld), .isqrt_y(isqrt_y),
    .busy(busy), .err_unexpected(err_unexpected)
  );

  // ---------------- isqrt stub (fixed latency, shares rst_n) ----------------
  int          lat;
  logic        inj_vld;
  logic [7:0]  pv;
  logic [15:0] py [8];

  function automatic logic [15:0] stub_sqrt(logic [31:0] x);
    logic [15:0] y;
    logic [15:0] t;
    y = '0;
    for (int b = 15; b >= 0; b--) begin
      t = y | (16'd1 << b);
      if (({16'd0, t} * {16'd0, t}) <= x) y = t;
    end
    return y;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pv <= '0;
    else        pv <= {pv[6:0], isqrt_x_vld};
  end

  always @(posedge clk) begin
    for (int k = 7; k > 0; k--) py[k] <= py[k-1];
    py[0] <= stub_sqrt(isqrt_x);
  end

  assign isqrt_y_vld = pv[lat-1] | inj_vld;
  assign isqrt_y     = inj_vld ? 16'hBEEF : py[lat-1];

  // ---------------- reference model / scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];
  int       out_cnt;
  int       rr;
  bit       err_exp;
  bit       rsp_due;
  logic [N-1:0] acc;

  function automatic logic [15:0] ref_sqrt(logic [31:0] x);
    longint v;
    longint y;
    v = longint'(x);
    y = longint'($floor($sqrt(real'(v))));
    while (y * y > v) y--;
    while ((y + 1) * (y + 1) <= v) y++;
    return y[15:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: occupancy, round-robin choice and response timing, from the rules alone.
  always @(negedge clk) begin
    int  g;
    bit  found;
    bit  iss;
    bit  pp;
    logic [31:0] xv;
    logic [15:0] yv;
    if (!rst_n) begin
      out_cnt = 0; rr = 0; err_exp = 0; rsp_due = 0; acc = '0;
      exp_q.delete();
    end else begin
      check("busy", 64'(busy), 64'(out_cnt != 0));
      check("err_unexpected", 64'(err_unexpected), 64'(err_exp));
      check("rsp_timing", 64'(rsp_vld != '0), 64'(rsp_due));
      found = 0; g = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && req_vld[(rr + k) % N]) begin
          g = (rr + k) % N;
          found = 1;
        end
      end
      iss = found && (out_cnt < MAX_OUT);
      check("req_ready", 64'(req_ready), iss ? 64'(1) << g : 64'(0));
      check("isqrt_x_vld", 64'(isqrt_x_vld), 64'(iss));
      if (iss) begin
        xv = req_x[32*g +: 32];
        yv = ref_sqrt(xv);
        check("isqrt_x", 64'(isqrt_x), 64'(xv));
        exp_q.push_back({8'(g), yv});
        rr = (g + 1) % N;
      end
      acc = req_vld & req_ready;
      pp = isqrt_y_vld && (out_cnt != 0);
      if (isqrt_y_vld && out_cnt == 0) err_exp = 1;
      rsp_due = pp;
      out_cnt = out_cnt + int'(iss) - int'(pp);
    end
  end

  // Monitor: pops the expected queue whenever a response is presented.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && rsp_vld != '0) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_vld), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("rsp_vld", 64'(rsp_vld), 64'(1) << e[23:16]);
        check("rsp_y", 64'(rsp_y), 64'(e[15:0]));
      end
    end
  end

  // ---------------- driver ----------------
  int          p_req [N];
  bit          use_fix;
  logic [31:0] fix_x [N];

  function automatic logic [31:0] rnd_x();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(4))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return {16'd0, r} * {16'd0, r};
      3: return ({16'd0, r} * {16'd0, r}) - 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Requesters hold vld/x until accepted, then randomly re-request or go idle.
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (!req_vld[i] || acc[i]) begin
          if ($urandom_range(99) < p_req[i]) begin
            req_vld[i] = 1'b1;
            req_x[32*i +: 32] = use_fix ? fix_x[i] : rnd_x();
          end else begin
            req_vld[i] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    p_req[0] = 0; p_req[1] = 0;
    run(2);
    while ((out_cnt != 0 || rsp_due || exp_q.size() != 0 || req_vld != '0) && c < budget) begin
      run(1);
      c++;
    end
    check("drain_done", 64'(c < budget), 64'(1));
  endtask

  task automatic check_idle_outputs(input string tag, input bit exp_err);
    check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    check({tag, "_x_vld"}, 64'(isqrt_x_vld), 64'(0));
    check({tag, "_x"}, 64'(isqrt_x), 64'(0));
    check({tag, "_rsp_vld"}, 64'(rsp_vld), 64'(0));
    check({tag, "_rsp_y"}, 64'(rsp_y), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_err"}, 64'(err_unexpected), 64'(exp_err));
  endtask

  initial begin
    rst_n = 1'b0; req_vld = '0; req_x = '0; inj_vld = 1'b0; lat = 3;
    p_req[0] = 0; p_req[1] = 0; use_fix = 0; fix_x[0] = 0; fix_x[1] = 0;
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("reset", 1'b0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Single request from requester 0, x=100 -> y=10.
    use_fix = 1; fix_x[0] = 32'd100; fix_x[1] = 32'd49;
    p_req[0] = 100; run(1); p_req[0] = 0; run(8);
    // One request from requester 1 returns the pointer to 0.
    p_req[1] = 100; run(1); p_req[1] = 0; drain(20);

    // Both requesters continuously valid: alternating grants.
    fix_x[0] = 32'd16; fix_x[1] = 32'hFFFF_FFFF;
    p_req[0] = 100; p_req[1] = 100; run(12);
    drain(30);

    // Long latency: fill to MAX_OUT and stall until a result frees a slot.
    lat = 6; use_fix = 0;
    p_req[0] = 100; p_req[1] = 0; run(24);
    drain(40);
    lat = 3;

    // Random traffic, including issue and pop in the same cycle at high occupancy.
    p_req[0] = 60; p_req[1] = 60; run(200);
    p_req[0] = 90; p_req[1] = 90; run(150);
    drain(50);

    // Result with nothing outstanding sets the sticky error.
    @(posedge clk); #1 inj_vld = 1'b1;
    @(posedge clk); #1 inj_vld = 1'b0;
    run(6);

    // Asynchronous reset with requests in flight.
    p_req[0] = 100; p_req[1] = 100; run(3);
    @(posedge clk); #3;
    rst_n = 1'b0; req_vld = '0;
    #1 check_idle_outputs("async_reset", 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    acc = '0;
    use_fix = 1; fix_x[0] = 32'd81; fix_x[1] = 32'd64;
    p_req[0] = 100; p_req[1] = 100; run(1);
    p_req[0] = 0; p_req[1] = 0;
    drain(30);
    run(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
